// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver: FSM states, parity modes,
// FIFO entry layout and the data-bits decode.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_PUSH, ST_BRK_WAIT
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic logic [3:0] data_bits(input logic [1:0] sel);
    return 4'd5 + {2'b00, sel};
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Register-side view of the receiver: FIFO pop port, status and interrupt.
interface uart_rx_param_if #(
  parameter int FIFO_AW = 4
);
  logic               rd_en;
  logic [7:0]         rd_data;
  logic               rd_parity_err;
  logic               rd_frame_err;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FIFO_AW:0]   fifo_level;
  logic               busy;
  logic               overrun;
  logic               break_det;
  logic               clr_sticky;
  logic               irq;
  logic [3:0]         irq_src;

  modport master (
    output rd_en, clr_sticky,
    input  rd_data, rd_parity_err, rd_frame_err, fifo_empty, fifo_full, fifo_level,
           busy, overrun, break_det, irq, irq_src
  );

  modport slave (
    input  rd_en, clr_sticky,
    output rd_data, rd_parity_err, rd_frame_err, fifo_empty, fifo_full, fifo_level,
           busy, overrun, break_det, irq, irq_src
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO with level output; a push while full only lands
// if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  level
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero while empty so the output matches its reset value.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver with runtime frame format, 3-sample majority voting, tagged
// receive FIFO, break/overrun/timeout detection and a combined level IRQ.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DIV_W        = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_clk_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic [FIFO_AW:0] cfg_thresh,
  input  logic             rx,
  uart_rx_param_if.slave   bus
);
  localparam int TO_W = DIV_W + 8;

  rx_state_t          state, state_nxt;
  logic               rx_s1, rx_s2, rx_d;
  logic [DIV_W-1:0]   cnt, div_l, centre;
  logic [3:0]         nbits_l, bit_idx;
  logic               par_en_l, par_odd_l, stop2_l;
  logic [7:0]         data_r;
  logic               par_r, ferr_r, s_a, s_b;
  logic               start_go, at_c1, at_c0, at_s, at_end, maj, brk;
  logic               busy, push, brk_set, perr, pop;
  fifo_entry_t        wentry, hentry;
  logic [ENTRY_W-1:0] hraw;
  logic               f_empty, f_full;
  logic [FIFO_AW:0]   f_level;
  logic [TO_W-1:0]    to_cnt, to_lim;
  logic               to_run, to_set, to_pend, overrun, break_det, thr, irq;
  logic [3:0]         irq_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      {rx_s1, rx_s2, rx_d} <= 3'b111;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign centre   = div_l >> 1;
  assign at_c1    = (cnt == centre - 1'b1);
  assign at_c0    = (cnt == centre);
  assign at_s     = (cnt == centre + 1'b1);
  assign at_end   = (cnt == div_l - 1'b1);
  assign maj      = (s_a & s_b) | (s_a & rx_s2) | (s_b & rx_s2);
  assign start_go = (state == ST_IDLE) && cfg_en && rx_d && !rx_s2;
  assign brk      = (data_r == 8'h00) && !(par_en_l && par_r) && !maj;
  assign perr     = par_en_l && (^data_r ^ par_r ^ par_odd_l);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start_go) state_nxt = ST_START;
      ST_START:    if (at_s && maj) state_nxt = ST_IDLE;
                   else if (at_end) state_nxt = ST_DATA;
      ST_DATA:     if (at_end && bit_idx == nbits_l)
                     state_nxt = par_en_l ? ST_PARITY : ST_STOP1;
      ST_PARITY:   if (at_end) state_nxt = ST_STOP1;
      // The last stop bit hands off at its sample point, leaving the rest of
      // the bit for PUSH so a back-to-back start edge is never missed.
      ST_STOP1:    if (at_s && brk) state_nxt = ST_BRK_WAIT;
                   else if (at_s && !stop2_l) state_nxt = ST_PUSH;
                   else if (at_end && stop2_l) state_nxt = ST_STOP2;
      ST_STOP2:    if (at_s) state_nxt = ST_PUSH;
      ST_PUSH:     state_nxt = ST_IDLE;
      ST_BRK_WAIT: if (rx_s2) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    push    = (state == ST_PUSH);
    brk_set = (state == ST_STOP1) && at_s && brk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      div_l     <= '0;
      nbits_l   <= '0;
      bit_idx   <= '0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      stop2_l   <= 1'b0;
      data_r    <= '0;
      par_r     <= 1'b0;
      ferr_r    <= 1'b0;
      s_a       <= 1'b1;
      s_b       <= 1'b1;
    end else if (start_go) begin
      // The edge cycle is sample 0 of the start bit.
      cnt       <= DIV_W'(1);
      div_l     <= cfg_clk_div;
      nbits_l   <= data_bits(cfg_data_bits);
      par_en_l  <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_odd_l <= (cfg_parity == PAR_ODD);
      stop2_l   <= cfg_stop2;
      bit_idx   <= '0;
      data_r    <= '0;
      par_r     <= 1'b0;
      ferr_r    <= 1'b0;
    end else if (busy) begin
      cnt <= at_end ? '0 : cnt + 1'b1;
      if (at_c1) s_a <= rx_s2;
      if (at_c0) s_b <= rx_s2;
      if (at_s) begin
        case (state)
          ST_DATA: begin
            data_r[bit_idx[2:0]] <= maj;
            bit_idx              <= bit_idx + 1'b1;
          end
          ST_PARITY:          par_r  <= maj;
          ST_STOP1, ST_STOP2: ferr_r <= ferr_r | ~maj;
          default: ;
        endcase
      end
    end
  end

  assign wentry = '{perr: perr, ferr: ferr_r, data: data_r};
  assign pop    = bus.rd_en && !f_empty;

  uart_rx_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (bus.rd_en),
    .rdata (hraw),
    .empty (f_empty),
    .full  (f_full),
    .level (f_level)
  );

  assign hentry = fifo_entry_t'(hraw);

  assign to_lim = TO_W'(TIMEOUT_BITS) * TO_W'(cfg_clk_div);
  assign to_run = (state == ST_IDLE) && !f_empty;
  // Single pulse on reaching the limit, so clr_sticky can drop the pending bit.
  assign to_set = to_run && !start_go && !pop && (to_cnt == to_lim - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || start_go || pop || !to_run) to_cnt <= '0;
    else if (to_cnt != to_lim)            to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
      to_pend   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (push && f_full && !bus.rd_en) overrun <= 1'b1;
      else if (bus.clr_sticky)          overrun <= 1'b0;
      if (brk_set)                      break_det <= 1'b1;
      else if (bus.clr_sticky)          break_det <= 1'b0;
      if (to_set)                       to_pend <= 1'b1;
      else if (bus.clr_sticky || f_empty) to_pend <= 1'b0;
      irq <= |irq_src;
    end
  end

  assign thr     = (cfg_thresh != '0) && (f_level >= cfg_thresh);
  assign irq_src = {break_det, overrun, to_pend, thr};

  assign bus.rd_data       = hentry.data;
  assign bus.rd_parity_err = hentry.perr;
  assign bus.rd_frame_err  = hentry.ferr;
  assign bus.fifo_empty    = f_empty;
  assign bus.fifo_full     = f_full;
  assign bus.fifo_level    = f_level;
  assign bus.busy          = busy;
  assign bus.overrun       = overrun;
  assign bus.break_det     = break_det;
  assign bus.irq           = irq;
  assign bus.irq_src       = irq_src;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed plus randomized frames checked against a frame-level model of the
// receiver; 4-deep FIFO so full/overrun are reachable quickly.
module tb_uart_rx_param;
  localparam int DIV_W = 32, FIFO_DEPTH = 4, FIFO_AW = 2, TIMEOUT_BITS = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_en;
  logic [DIV_W-1:0] cfg_clk_div;
  logic [1:0]       cfg_data_bits, cfg_parity;
  logic             cfg_stop2;
  logic [FIFO_AW:0] cfg_thresh;
  logic             rx;

  uart_rx_param_if #(.FIFO_AW(FIFO_AW)) bus ();

  uart_rx_param #(
    .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_clk_div(cfg_clk_div),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .cfg_thresh(cfg_thresh), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0, n_err = 0;
  int         lat;
  logic       busy_seen;
  logic [9:0] exp_q[$];

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO entry {perr, ferr, data} for one transmitted frame.
  function automatic logic [9:0] model(input logic [7:0] d, input int nb, input logic [1:0] pm,
                                       input logic s2, input logic bad_par, input logic bad_s1,
                                       input logic bad_s2);
    logic [7:0] dm = d & 8'((1 << nb) - 1);
    logic       pe = (pm == 2'b01) || (pm == 2'b10);
    return {pe && bad_par, bad_s1 || (s2 && bad_s2), dm};
  endfunction

  task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] pm,
                            input logic s2, input logic bad_par, input logic bad_s1,
                            input logic bad_s2);
    logic             bits[$];
    int               ones = 0;
    int               cyc  = 0;
    int               div  = int'(cfg_clk_div);
    logic [FIFO_AW:0] lvl0 = bus.fifo_level;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 2'b01) bits.push_back(((ones % 2) == 1) ^ bad_par);
    if (pm == 2'b10) bits.push_back(((ones % 2) == 0) ^ bad_par);
    bits.push_back(!bad_s1);
    if (s2) bits.push_back(!bad_s2);
    bits.push_back(1'b1);
    bits.push_back(1'b1);
    lat = -1;
    busy_seen = 1'b0;
    foreach (bits[k]) begin
      rx = bits[k];
      repeat (div) begin
        tick();
        cyc++;
        if (bus.busy) busy_seen = 1'b1;
        if (lat < 0 && bus.fifo_level != lvl0) lat = cyc;
      end
    end
  endtask

  task automatic set_cfg(input int div, input logic [1:0] db, input logic [1:0] pm, input logic s2);
    cfg_clk_div   = DIV_W'(div);
    cfg_data_bits = db;
    cfg_parity    = pm;
    cfg_stop2     = s2;
  endtask

  task automatic pop_chk(input string tag);
    logic [9:0] e;
    e = exp_q.pop_front();
    chk({tag, "_nonempty"}, bus.fifo_empty, 1'b0);
    chk({tag, "_data"}, bus.rd_data, e[7:0]);
    chk({tag, "_ferr"}, bus.rd_frame_err, e[8]);
    chk({tag, "_perr"}, bus.rd_parity_err, e[9]);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] db, pm;
    logic       s2, bp, bs1, bs2;
    int         nb, found, idle;

    rst = 1'b1; cfg_en = 1'b1; cfg_thresh = '0; rx = 1'b1;
    set_cfg(16, 2'b11, 2'b00, 1'b0);
    bus.rd_en = 1'b0; bus.clr_sticky = 1'b0;
    tick(3);
    chk("rst_empty", bus.fifo_empty, 1'b1);
    chk("rst_level", bus.fifo_level, 0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_irq", bus.irq, 1'b0);
    chk("rst_irq_src", bus.irq_src, 4'h0);
    chk("rst_full", bus.fifo_full, 1'b0);
    chk("rst_data", bus.rd_data, 8'h00);
    chk("rst_sticky", {bus.overrun, bus.break_det}, 2'b00);
    rst = 1'b0;
    tick(2);

    // 8N1 single character and push latency
    send_frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("t1_latency_ok", (lat >= 150 && lat <= 160), 1'b1);
    chk("t1_busy_seen", busy_seen, 1'b1);
    chk("t1_busy_idle", bus.busy, 1'b0);
    chk("t1_level", bus.fifo_level, 1);
    pop_chk("t1");
    chk("t1_empty_after_pop", bus.fifo_empty, 1'b1);

    // 7E2: bad parity, then bad second stop bit only
    set_cfg(16, 2'b10, 2'b01, 1'b1);
    send_frame(8'h35, 7, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(model(8'h35, 7, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
    pop_chk("t2_par");
    send_frame(8'h35, 7, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(model(8'h35, 7, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1));
    pop_chk("t2_stop2");

    // start-bit glitch
    set_cfg(16, 2'b11, 2'b00, 1'b0);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    busy_seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.busy) busy_seen = 1'b1;
    end
    chk("t3_busy_pulse", busy_seen, 1'b1);
    chk("t3_busy_idle", bus.busy, 1'b0);
    chk("t3_no_push", bus.fifo_level, 0);
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    pop_chk("t3");

    // randomized formats and error injection
    for (int t = 0; t < 10; t++) begin
      db  = 2'($urandom_range(0, 3));
      pm  = 2'($urandom_range(0, 3));
      s2  = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs1 = ($urandom_range(0, 3) == 0);
      bs2 = ($urandom_range(0, 3) == 0);
      nb  = 5 + int'(db);
      if ((d & 8'((1 << nb) - 1)) == 8'h00) bs1 = 1'b0;
      set_cfg(int'($urandom_range(8, 24)), db, pm, s2);
      send_frame(d, nb, pm, s2, bp, bs1, bs2);
      exp_q.push_back(model(d, nb, pm, s2, bp, bs1, bs2));
      chk("rnd_pushed", (lat >= 0), 1'b1);
      pop_chk("rnd");
    end

    // fill past depth: overrun, threshold, in-order drain
    set_cfg(16, 2'b11, 2'b00, 1'b0);
    cfg_thresh = 3'd3;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(model(d, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    tick();
    chk("t4_full", bus.fifo_full, 1'b1);
    chk("t4_level", bus.fifo_level, FIFO_DEPTH);
    chk("t4_overrun", bus.overrun, 1'b1);
    chk("t4_irq_src", bus.irq_src, 4'b0101);
    chk("t4_irq", bus.irq, 1'b1);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_chk("t4_drain");
    chk("t4_empty", bus.fifo_empty, 1'b1);
    chk("t4_irq_src_drained", bus.irq_src, 4'b0100);
    bus.clr_sticky = 1'b1;
    tick();
    bus.clr_sticky = 1'b0;
    chk("t4_overrun_clr", bus.overrun, 1'b0);
    tick();
    chk("t4_irq_clr", bus.irq, 1'b0);
    cfg_thresh = '0;

    // idle timeout
    send_frame(8'h11, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model(8'h11, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    found = -1;
    for (int i = 0; i < 800; i++) begin
      if (bus.irq_src[1]) begin
        found = i;
        break;
      end
      tick();
    end
    idle = found + 12 * 16 - lat;
    chk("t5_timeout_fired", (found >= 0), 1'b1);
    chk("t5_timeout_time", (idle >= 636 && idle <= 644), 1'b1);
    tick();
    chk("t5_irq", bus.irq, 1'b1);
    pop_chk("t5");
    tick();
    chk("t5_pend_cleared", bus.irq_src[1], 1'b0);

    // break, then a normal frame
    rx = 1'b0;
    tick(12 * 16);
    rx = 1'b1;
    tick(32);
    chk("t6_break", bus.break_det, 1'b1);
    chk("t6_no_push", bus.fifo_level, 0);
    chk("t6_irq_src", bus.irq_src[3], 1'b1);
    chk("t6_busy", bus.busy, 1'b0);
    send_frame(8'h7E, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_data", bus.rd_data, 8'h7E);
    chk("t6_level", bus.fifo_level, 1);

    // reset in the middle of the data bits
    rx = 1'b0;
    tick(3 * 16);
    chk("t6_mid_busy", bus.busy, 1'b1);
    rst = 1'b1;
    rx  = 1'b1;
    tick();
    chk("t6r_busy", bus.busy, 1'b0);
    chk("t6r_empty", bus.fifo_empty, 1'b1);
    chk("t6r_level", bus.fifo_level, 0);
    chk("t6r_data", bus.rd_data, 8'h00);
    chk("t6r_sticky", {bus.overrun, bus.break_det}, 2'b00);
    chk("t6r_irq", {bus.irq, bus.irq_src}, 5'b0);
    rst = 1'b0;
    exp_q.delete();
    tick(200);
    chk("t6r_no_partial", bus.fifo_level, 0);
    chk("t6r_idle", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
